// File: rtl/drop_animator_if.sv
// Move-entry / animator bundle: drop request and column snapshot in, animation and commit status out.
interface drop_animator_if #(
  parameter int ROWS  = 16,
  parameter int ROW_W = 4,
  parameter int COL_W = 4
);
  logic             tick_n;
  logic             start;
  logic [COL_W-1:0] col;
  logic             player;
  logic [ROWS-1:0]  col_occ;

  logic             busy;
  logic             anim_valid;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             cur_player;
  logic             done;
  logic [ROW_W-1:0] land_row;
  logic             full_err;

  modport master (
    output tick_n, start, col, player, col_occ,
    input  busy, anim_valid, cur_row, cur_col, cur_player, done, land_row, full_err
  );

  modport slave (
    input  tick_n, start, col, player, col_occ,
    output busy, anim_valid, cur_row, cur_col, cur_player, done, land_row, full_err
  );
endinterface

// File: rtl/drop_animator.sv
// Animates a played token falling down one column, one row per low tick_n, then pulses done to commit it.
// Define DROP_ANIM_BYPASS_EN to skip the fall and commit directly after the landing check.
module drop_animator #(
  parameter int ROWS  = 16,
  parameter int ROW_W = 4,
  parameter int COL_W = 4
) (
  input logic            clk,
  input logic            RST,
  drop_animator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CHECK, FALL, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             player_q, player_d;
  logic [ROWS-1:0]  occ_q, occ_d;
  logic [ROW_W-1:0] cur_row_q, cur_row_d;
  logic [ROW_W-1:0] land_row_q, land_row_d;
  logic             anim_valid_q, anim_valid_d;
  logic             done_q, done_d;
  logic             full_err_q, full_err_d;
  logic [ROW_W-1:0] land_calc;

  // Row just above the topmost filled cell; cells below it are don't-care.
  function automatic logic [ROW_W-1:0] land_of(input logic [ROWS-1:0] occ);
    logic [ROW_W-1:0] r;
    r = ROW_W'(ROWS - 1);
    for (int i = ROWS - 1; i >= 1; i--) begin
      if (occ[i]) r = ROW_W'(i - 1);
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    player_d     = player_q;
    occ_d        = occ_q;
    cur_row_d    = cur_row_q;
    land_row_d   = land_row_q;
    anim_valid_d = anim_valid_q;
    done_d       = 1'b0;
    full_err_d   = 1'b0;
    land_calc    = land_of(occ_q);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          col_d    = bus.col;
          player_d = bus.player;
          occ_d    = bus.col_occ;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (occ_q[0]) begin
          full_err_d = 1'b1;
          state_d    = IDLE;
        end else begin
          land_row_d = land_calc;
`ifdef DROP_ANIM_BYPASS_EN
          cur_row_d  = land_calc;
          done_d     = 1'b1;
          state_d    = COMMIT;
`else
          cur_row_d    = '0;
          anim_valid_d = 1'b1;
          state_d      = FALL;
`endif
        end
      end
      FALL: begin
        // The landing row gets one dwell step before the commit.
        if (!bus.tick_n) begin
          if (cur_row_q < land_row_q) begin
            cur_row_d = cur_row_q + ROW_W'(1);
          end else begin
            anim_valid_d = 1'b0;
            done_d       = 1'b1;
            state_d      = COMMIT;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q      <= IDLE;
      col_q        <= '0;
      player_q     <= 1'b0;
      cur_row_q    <= '0;
      land_row_q   <= '0;
      anim_valid_q <= 1'b0;
      done_q       <= 1'b0;
      full_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      player_q     <= player_d;
      cur_row_q    <= cur_row_d;
      land_row_q   <= land_row_d;
      anim_valid_q <= anim_valid_d;
      done_q       <= done_d;
      full_err_q   <= full_err_d;
    end
  end

  always_ff @(posedge clk) begin
    occ_q <= occ_d;
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.anim_valid = anim_valid_q;
  assign bus.cur_row    = cur_row_q;
  assign bus.cur_col    = col_q;
  assign bus.cur_player = player_q;
  assign bus.done       = done_q;
  assign bus.land_row   = land_row_q;
  assign bus.full_err   = full_err_q;

endmodule

// File: tb/tb_drop_animator.sv
// Bench for drop_animator: table of drops scored through an expectation queue, plus reset corner cases.
module tb_drop_animator;

  typedef struct {
    logic [3:0]  col;
    logic        player;
    logic [15:0] occ;
    int          land;
    bit          full;
    int          tper;
  } vec_t;

  typedef struct {
    int col;
    int player;
    int land;
    bit full;
  } exp_t;

  logic clk;
  logic RST;
  int   checks;
  int   errors;
  exp_t sb[$];
  vec_t vecs[8];

  drop_animator_if #(.ROWS(16), .ROW_W(4), .COL_W(4)) bus ();

  drop_animator #(.ROWS(16), .ROW_W(4), .COL_W(4)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_drop(input vec_t v, input bit spam);
    exp_t e;
    int   cyc, ticks, ph, prev_row;
    bit   ev, prev_av, old_av, tick_low;
    e.col = v.col; e.player = v.player; e.land = v.land; e.full = v.full;
    sb.push_back(e);
    bus.col     = v.col;
    bus.player  = v.player;
    bus.col_occ = v.occ;
    bus.tick_n  = 1'b1;
    bus.start   = 1'b1;
    cyc = 0; ticks = 0; ph = 0; ev = 0; prev_av = 0; prev_row = 0;
    while (!ev && cyc < 400) begin
      tick_low = (bus.tick_n == 1'b0);
      @(negedge clk);
      cyc++;
      if (prev_av && tick_low) ticks++;
      old_av  = prev_av;
      prev_av = bus.anim_valid;
`ifdef DROP_ANIM_BYPASS_EN
      chk("bypass_anim_valid", bus.anim_valid, 0);
`endif
      if (bus.anim_valid) begin
        chk("row_bound", (int'(bus.cur_row) > v.land), 0);
        if (!old_av) chk("row_first", bus.cur_row, 0);
        else chk("row_step", (int'(bus.cur_row) - prev_row) inside {0, 1}, 1);
        prev_row = bus.cur_row;
      end
      if (spam && bus.busy) chk("cur_col_hold", bus.cur_col, v.col);
      if (bus.done || bus.full_err) begin
        ev = 1;
        e  = sb.pop_front();
        chk("one_event", bus.done && bus.full_err, 0);
        chk("is_full", bus.full_err, e.full);
        if (e.full) begin
          chk("full_lat", cyc, 2);
          chk("full_busy", bus.busy, 0);
        end else begin
          chk("land_row", bus.land_row, e.land);
          chk("commit_row", bus.cur_row, e.land);
          chk("commit_col", bus.cur_col, e.col);
          chk("commit_player", bus.cur_player, e.player);
          chk("commit_av", bus.anim_valid, 0);
          chk("commit_busy", bus.busy, 1);
`ifdef DROP_ANIM_BYPASS_EN
          chk("done_lat", cyc, 2);
`else
          chk("tick_count", ticks, e.land + 1);
`endif
        end
      end else begin
        chk("busy_inflight", bus.busy, 1);
      end
      bus.start = spam && bus.busy;
      bus.col   = (spam && bus.busy) ? (v.col ^ 4'h1) : v.col;
      ph++;
      bus.tick_n = ((ph % v.tper) == 0) ? 1'b0 : 1'b1;
    end
    if (!ev) chk("event_timeout", 0, 1);
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_done", bus.done, 0);
      chk("post_full", bus.full_err, 0);
      chk("post_busy", bus.busy, 0);
    end
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    vecs[0] = '{4'd5,  1'b1, 16'h0000, 15, 1'b0, 4};
    vecs[1] = '{4'd3,  1'b0, 16'hF000, 11, 1'b0, 4};
    vecs[2] = '{4'd9,  1'b1, 16'hFFFF, 0,  1'b1, 4};
    vecs[3] = '{4'd0,  1'b0, 16'h8000, 14, 1'b0, 3};
    vecs[4] = '{4'd15, 1'b1, 16'h0002, 0,  1'b0, 1};
    vecs[5] = '{4'd7,  1'b0, 16'h0A50, 3,  1'b0, 2};
    vecs[6] = '{4'd2,  1'b1, 16'h0001, 0,  1'b1, 1};
    vecs[7] = '{4'd12, 1'b0, 16'h0100, 7,  1'b0, 1};

    RST = 1'b0;
    bus.tick_n = 1'b1; bus.start = 1'b0; bus.col = '0; bus.player = 1'b0; bus.col_occ = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_av", bus.anim_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_full", bus.full_err, 0);
    chk("rst_row", bus.cur_row, 0);
    chk("rst_col", bus.cur_col, 0);
    chk("rst_player", bus.cur_player, 0);
    chk("rst_land", bus.land_row, 0);
    RST = 1'b1;
    @(negedge clk);

    // start is ignored in IDLE-only sense: tick alone must not start anything
    bus.tick_n = 1'b0;
    @(negedge clk);
    chk("tick_idle_busy", bus.busy, 0);
    bus.tick_n = 1'b1;

    for (int i = 0; i < 8; i++) run_drop(vecs[i], (i == 1));

    // Reset in the middle of a drop
    sb.push_back('{4, 1, 15, 1'b0});
    bus.col = 4'd4; bus.player = 1'b1; bus.col_occ = 16'h0000; bus.start = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      bus.start  = 1'b0;
      bus.tick_n = ((n % 2) == 0) ? 1'b0 : 1'b1;
`ifdef DROP_ANIM_BYPASS_EN
      if (bus.busy) break;
`else
      if (bus.anim_valid && bus.cur_row == 4'd7) break;
`endif
    end
    chk("mid_reached", (n < 200), 1);
    RST = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_row", bus.cur_row, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_av", bus.anim_valid, 0);
    chk("mid_rst_col", bus.cur_col, 0);
    RST = 1'b1;
    sb.delete();
    bus.tick_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_no_done", bus.done, 0);
      chk("mid_idle", bus.busy, 0);
    end
    bus.tick_n = 1'b1;
    run_drop('{4'd6, 1'b1, 16'hC000, 13, 1'b0, 2}, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
